// File: rtl/sequence_loader.sv
// sequence_loader
//   Write-side front end for the alignment core. Converts a stream of ASCII
//   nucleotide characters into 3-bit symbol codes and drives the sequence-RAM
//   write ports. Sequence A is loaded first, then sequence B, each terminated
//   by ';'. Lengths and sticky error flags are reported, and done is raised
//   once both sequences are stored.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   start               begin a new load (honoured in IDLE / DONE only)
//   in_data, in_valid   ASCII character stream
//   in_ready            loader accepts a character this cycle
//   din_ram, en_ram     symbol code and RAM enable (write cycles only)
//   weA, weB            write strobes for sequence A / B RAM
//   addr_dinA/B         1-based write address (0 when not writing)
//   len_a, len_b        stored symbol counts
//   done                both sequences terminated
//   err_char/ovf/empty  sticky error flags, cleared by start
module sequence_loader #(
    parameter int N       = 128,
    parameter int BitAddr = $clog2(N + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [2:0]         din_ram,
    output logic               en_ram,
    output logic               weA,
    output logic               weB,
    output logic [BitAddr:0]   addr_dinA,
    output logic [BitAddr:0]   addr_dinB,
    output logic [BitAddr:0]   len_a,
    output logic [BitAddr:0]   len_b,
    output logic               done,
    output logic               err_char,
    output logic               err_ovf,
    output logic               err_empty
);

    localparam int AW = BitAddr + 1;
    localparam logic [AW-1:0] NMAX = AW'(N);

    typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, DONE} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   len_a_q, len_a_d, len_b_q, len_b_d;
    logic [AW-1:0]   addr_a_q, addr_a_d, addr_b_q, addr_b_d;
    logic [2:0]      din_q, din_d;
    logic            en_q, en_d, we_a_q, we_a_d, we_b_q, we_b_d;
    logic            ready_q, ready_d, done_q, done_d;
    logic            ech_q, ech_d, eovf_q, eovf_d, eemp_q, eemp_d;

    // Character decode
    logic            is_sym, is_sep, accept;
    logic [2:0]      code;
    logic [AW-1:0]   cur_len, nxt_len;

    always_comb begin
        is_sym = 1'b1;
        code   = 3'b000;
        case (in_data)
            8'h41, 8'h61: code = 3'b000;   // A a
            8'h43, 8'h63: code = 3'b001;   // C c
            8'h47, 8'h67: code = 3'b010;   // G g
            8'h54, 8'h74: code = 3'b011;   // T t
            default:      is_sym = 1'b0;
        endcase
        is_sep  = (in_data == 8'h3B);
        // ready_q is high exactly in LOAD_A / LOAD_B
        accept  = in_valid && ready_q;
        cur_len = (state_q == LOAD_B) ? len_b_q : len_a_q;
        nxt_len = cur_len + AW'(1);
    end

    always_comb begin
        state_d  = state_q;
        len_a_d  = len_a_q;
        len_b_d  = len_b_q;
        ech_d    = ech_q;
        eovf_d   = eovf_q;
        eemp_d   = eemp_q;
        // write-port outputs are single-cycle pulses, zero unless writing
        en_d     = 1'b0;
        we_a_d   = 1'b0;
        we_b_d   = 1'b0;
        din_d    = 3'b000;
        addr_a_d = '0;
        addr_b_d = '0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = LOAD_A;
                    len_a_d = '0;
                    len_b_d = '0;
                    ech_d   = 1'b0;
                    eovf_d  = 1'b0;
                    eemp_d  = 1'b0;
                end
            end
            LOAD_A, LOAD_B: begin
                if (accept) begin
                    if (is_sym) begin
                        if (cur_len < NMAX) begin
                            en_d  = 1'b1;
                            din_d = code;
                            if (state_q == LOAD_A) begin
                                len_a_d  = nxt_len;
                                we_a_d   = 1'b1;
                                addr_a_d = nxt_len;
                            end else begin
                                len_b_d  = nxt_len;
                                we_b_d   = 1'b1;
                                addr_b_d = nxt_len;
                            end
                        end else begin
                            eovf_d = 1'b1;
                        end
                    end else if (is_sep) begin
                        if (cur_len == '0) eemp_d = 1'b1;
                        state_d = (state_q == LOAD_A) ? LOAD_B : DONE;
                    end else begin
                        ech_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // status outputs reflect the state entered on this edge
        ready_d = (state_d == LOAD_A) || (state_d == LOAD_B);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            len_a_q  <= '0;
            len_b_q  <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            din_q    <= 3'b000;
            en_q     <= 1'b0;
            we_a_q   <= 1'b0;
            we_b_q   <= 1'b0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            ech_q    <= 1'b0;
            eovf_q   <= 1'b0;
            eemp_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_a_q  <= len_a_d;
            len_b_q  <= len_b_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            din_q    <= din_d;
            en_q     <= en_d;
            we_a_q   <= we_a_d;
            we_b_q   <= we_b_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            ech_q    <= ech_d;
            eovf_q   <= eovf_d;
            eemp_q   <= eemp_d;
        end
    end

    assign in_ready  = ready_q;
    assign din_ram   = din_q;
    assign en_ram    = en_q;
    assign weA       = we_a_q;
    assign weB       = we_b_q;
    assign addr_dinA = addr_a_q;
    assign addr_dinB = addr_b_q;
    assign len_a     = len_a_q;
    assign len_b     = len_b_q;
    assign done      = done_q;
    assign err_char  = ech_q;
    assign err_ovf   = eovf_q;
    assign err_empty = eemp_q;

endmodule

// File: tb/tb_sequence_loader.sv
// Directed bench for sequence_loader: a default (N=128) instance and an N=4
// instance share one input stream; negedge monitors log RAM writes.
module tb_sequence_loader;

    logic       clk, rst, start, in_valid;
    logic [7:0] in_data;

    // N = 128 instance (BitAddr = 8, 9-bit buses)
    logic       rdy, en, wa, wb, dn, ec, eo, ee;
    logic [2:0] din;
    logic [8:0] ada, adb, la, lb;
    // N = 4 instance (BitAddr = 3, 4-bit buses)
    logic       s_rdy, s_en, s_wa, s_wb, s_dn, s_ec, s_eo, s_ee;
    logic [2:0] s_din;
    logic [3:0] s_ada, s_adb, s_la, s_lb;

    int tests = 0, fails = 0;

    sequence_loader u_dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy), .din_ram(din), .en_ram(en), .weA(wa), .weB(wb),
        .addr_dinA(ada), .addr_dinB(adb), .len_a(la), .len_b(lb), .done(dn),
        .err_char(ec), .err_ovf(eo), .err_empty(ee));

    sequence_loader #(.N(4)) u_small (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(s_rdy), .din_ram(s_din), .en_ram(s_en), .weA(s_wa), .weB(s_wb),
        .addr_dinA(s_ada), .addr_dinB(s_adb), .len_a(s_la), .len_b(s_lb), .done(s_dn),
        .err_char(s_ec), .err_ovf(s_eo), .err_empty(s_ee));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // write logs: memories keep last written code, counters only grow
    logic [2:0] memA [0:511];
    logic [2:0] memB [0:511];
    logic [2:0] smemA[0:15];
    logic [2:0] smemB[0:15];
    int wcA = 0, wcB = 0, swA = 0, swB = 0, bad = 0;

    always @(negedge clk) begin
        if (en) begin
            if (wa && !wb && adb == 0 && ada != 0) begin memA[ada] = din; wcA++; end
            else if (wb && !wa && ada == 0 && adb != 0) begin memB[adb] = din; wcB++; end
            else bad++;
        end else if (wa || wb || din != 0 || ada != 0 || adb != 0) bad++;
        if (s_en) begin
            if (s_wa && !s_wb) begin smemA[s_ada] = s_din; swA++; end
            else if (s_wb && !s_wa) begin smemB[s_adb] = s_din; swB++; end
            else bad++;
        end
    end

    task automatic send(input logic [7:0] b);
        in_data = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = 8'h00;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        idle(2);
        tests++;
        if ({rdy, dn, en, wa, wb, din, ada, adb, la, lb, ec, eo, ee} !== '0) begin
            fails++; $display("FAIL reset_outputs: got %h exp 0",
                {rdy, dn, en, wa, wb, din, ada, adb, la, lb, ec, eo, ee});
        end
        // start while held in reset must have no effect
        start = 1'b1; idle(1); start = 1'b0;
        tests++;
        if (rdy !== 1'b0) begin fails++; $display("FAIL reset_hold_ready: got %b exp 0", rdy); end
        rst = 1'b1;
        idle(2);
        tests++;
        if ({rdy, dn} !== 2'b00) begin fails++; $display("FAIL idle_after_reset: rdy,done got %b exp 00", {rdy, dn}); end
    endtask

    task automatic test_basic();
        int a0, b0;
        a0 = wcA; b0 = wcB;
        do_start();
        tests++;
        if ({rdy, dn, la, lb} !== {1'b1, 1'b0, 9'd0, 9'd0}) begin
            fails++; $display("FAIL start_state: rdy=%b done=%b la=%0d lb=%0d exp 1 0 0 0", rdy, dn, la, lb);
        end
        send("A");
        // write pulse and new length both visible right after the acceptance edge
        tests++;
        if ({en, wa, wb, din, ada, la} !== {1'b1, 1'b1, 1'b0, 3'b000, 9'd1, 9'd1}) begin
            fails++; $display("FAIL first_write: en=%b weA=%b weB=%b din=%b addrA=%0d la=%0d exp 1 1 0 000 1 1",
                en, wa, wb, din, ada, la);
        end
        send_str("CGT;GA");
        tests++;
        if (dn !== 1'b0) begin fails++; $display("FAIL done_early: got %b exp 0", dn); end
        send(";");
        tests++;
        if ({dn, rdy} !== 2'b10) begin fails++; $display("FAIL done_after_sep: done,rdy got %b exp 10", {dn, rdy}); end
        idle(1);
        tests++;
        if ({memA[1], memA[2], memA[3], memA[4]} !== 12'b000_001_010_011) begin
            fails++; $display("FAIL basic_codes_A: got %b exp 000001010011",
                {memA[1], memA[2], memA[3], memA[4]});
        end
        tests++;
        if ({memB[1], memB[2]} !== 6'b010_000) begin
            fails++; $display("FAIL basic_codes_B: got %b exp 010000", {memB[1], memB[2]});
        end
        tests++;
        if ({la, lb, wcA - a0, wcB - b0, ec, eo, ee} !== {9'd4, 9'd2, 32'd4, 32'd2, 3'b000}) begin
            fails++; $display("FAIL basic_len_cnt: la=%0d lb=%0d wA=%0d wB=%0d err=%b exp 4 2 4 2 000",
                la, lb, wcA - a0, wcB - b0, {ec, eo, ee});
        end
        tests++;
        if ({en, wa, wb, din, ada, adb} !== '0) begin
            fails++; $display("FAIL idle_write_port: got %h exp 0", {en, wa, wb, din, ada, adb});
        end
    endtask

    task automatic test_lowercase();
        string s;
        int a0, b0;
        s = "acg;t;";
        a0 = wcA; b0 = wcB;
        memA[1] = 3'b111; memA[2] = 3'b111; memA[3] = 3'b111; memB[1] = 3'b111;
        do_start();
        for (int i = 0; i < s.len(); i++) begin
            send(s[i]);
            // unaccepted junk while in_valid is low
            in_data = 8'h58; idle(1); in_data = 8'h00;
        end
        tests++;
        if ({memA[1], memA[2], memA[3], memB[1]} !== 12'b000_001_010_011) begin
            fails++; $display("FAIL lower_codes: got %b exp 000001010011",
                {memA[1], memA[2], memA[3], memB[1]});
        end
        tests++;
        if ({la, lb, wcA - a0, wcB - b0, ec, dn} !== {9'd3, 9'd1, 32'd3, 32'd1, 1'b0, 1'b1}) begin
            fails++; $display("FAIL lower_len_cnt: la=%0d lb=%0d wA=%0d wB=%0d ech=%b done=%b exp 3 1 3 1 0 1",
                la, lb, wcA - a0, wcB - b0, ec, dn);
        end
    endtask

    task automatic test_bad_char();
        int a0;
        a0 = wcA;
        memA[2] = 3'b111;
        do_start();
        send_str("AXC");
        send(8'h0A);
        send_str(";T;");
        idle(1);
        tests++;
        if ({ec, eo, ee} !== 3'b100) begin fails++; $display("FAIL err_char: flags got %b exp 100", {ec, eo, ee}); end
        tests++;
        if ({memA[1], memA[2], la, lb, wcA - a0} !== {3'b000, 3'b001, 9'd2, 9'd1, 32'd2}) begin
            fails++; $display("FAIL badchar_writes: A1=%b A2=%b la=%0d lb=%0d wA=%0d exp 000 001 2 1 2",
                memA[1], memA[2], la, lb, wcA - a0);
        end
    endtask

    task automatic test_overflow();
        int sa0, sb0;
        sa0 = swA; sb0 = swB;
        do_start();
        send_str("ACGTA;C;");
        idle(1);
        tests++;
        if ({s_la, s_lb, s_eo, s_ec, s_ee, s_dn} !== {4'd4, 4'd1, 4'b1001}) begin
            fails++; $display("FAIL ovf_small: la=%0d lb=%0d ovf,ch,emp,done=%b exp 4 1 1001",
                s_la, s_lb, {s_eo, s_ec, s_ee, s_dn});
        end
        tests++;
        if ({swA - sa0, swB - sb0, smemA[4], smemB[1]} !== {32'd4, 32'd1, 3'b011, 3'b001}) begin
            fails++; $display("FAIL ovf_writes: wA=%0d wB=%0d A4=%b B1=%b exp 4 1 011 001",
                swA - sa0, swB - sb0, smemA[4], smemB[1]);
        end
        // the full-size instance keeps all five symbols
        tests++;
        if ({la, eo, memA[5]} !== {9'd5, 1'b0, 3'b000}) begin
            fails++; $display("FAIL ovf_big: la=%0d ovf=%b A5=%b exp 5 0 000", la, eo, memA[5]);
        end
    endtask

    task automatic test_empty();
        int a0, b0;
        a0 = wcA; b0 = wcB;
        do_start();
        send_str(";;");
        idle(1);
        tests++;
        if ({ee, dn, la, lb, wcA - a0, wcB - b0} !== {2'b11, 9'd0, 9'd0, 32'd0, 32'd0}) begin
            fails++; $display("FAIL empty_seqs: emp=%b done=%b la=%0d lb=%0d wA=%0d wB=%0d exp 1 1 0 0 0 0",
                ee, dn, la, lb, wcA - a0, wcB - b0);
        end
        do_start();
        tests++;
        if ({ee, ec, eo, dn, rdy, la, lb} !== {5'b00001, 9'd0, 9'd0}) begin
            fails++; $display("FAIL restart_clears: emp,ch,ovf,done,rdy=%b la=%0d lb=%0d exp 00001 0 0",
                {ee, ec, eo, dn, rdy}, la, lb);
        end
    endtask

    task automatic test_back_to_back();
        // already in LOAD_A from the previous restart
        send_str("AC");
        do_start();   // ignored mid-load
        tests++;
        if ({la, rdy} !== {9'd2, 1'b1}) begin
            fails++; $display("FAIL start_ignored: la=%0d rdy=%b exp 2 1", la, rdy);
        end
        send_str("T;;");
        idle(1);
        tests++;
        if ({la, lb, memA[3], ee, dn} !== {9'd3, 9'd0, 3'b011, 2'b11}) begin
            fails++; $display("FAIL b2b_result: la=%0d lb=%0d A3=%b emp=%b done=%b exp 3 0 011 1 1",
                la, lb, memA[3], ee, dn);
        end
        // restart straight out of DONE clears the flags
        do_start();
        tests++;
        if ({ee, dn, rdy, la} !== {3'b001, 9'd0}) begin
            fails++; $display("FAIL restart_from_done: emp,done,rdy=%b la=%0d exp 001 0", {ee, dn, rdy}, la);
        end
    endtask

    task automatic test_reset_mid();
        int b0;
        b0 = wcB;
        send_str("A;");
        send("G");
        tests++;
        if ({en, wb, adb, lb} !== {2'b11, 9'd1, 9'd1}) begin
            fails++; $display("FAIL pre_reset_write: en=%b weB=%b addrB=%0d lb=%0d exp 1 1 1 1", en, wb, adb, lb);
        end
        rst = 1'b0;
        #1;
        tests++;
        if ({rdy, dn, en, wa, wb, din, ada, adb, la, lb, ec, eo, ee} !== '0) begin
            fails++; $display("FAIL reset_mid_outputs: got %h exp 0",
                {rdy, dn, en, wa, wb, din, ada, adb, la, lb, ec, eo, ee});
        end
        #1 rst = 1'b1;
        idle(3);
        tests++;
        if ({rdy, dn, wcB - b0} !== {2'b00, 32'd0}) begin
            fails++; $display("FAIL post_reset_idle: rdy=%b done=%b wB=%0d exp 0 0 0", rdy, dn, wcB - b0);
        end
        do_start();
        tests++;
        if (rdy !== 1'b1) begin fails++; $display("FAIL post_reset_start: rdy got %b exp 1", rdy); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lowercase();
        test_bad_char();
        test_overflow();
        test_empty();
        test_back_to_back();
        test_reset_mid();
        tests++;
        if (bad !== 0) begin fails++; $display("FAIL write_port_protocol: violations got %0d exp 0", bad); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
